avalon_mem_responder: RTL and testbench
=======================================

AVALON_MEM_RESPONDER -- requirements
Module: avalon_mem_responder

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_W, 10, word-address width, memory depth 2^ADDR_W 32-bit words.
REQ-002 READ_LAT, 3, cycles from read acceptance to readdatavalid, legal range 1..8.
REQ-003 MAX_PEND, 2, max reads in flight, legal range 1..READ_LAT.
REQ-004 REF_PERIOD, 64, cycles between refresh stalls, minimum 8.
REQ-005 REF_CYCLES, 4, length of each refresh stall, range 1..REF_PERIOD-1.
REQ-006 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_W  word address.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  32  write data.
- byteenable  in  4  per-byte write enable, bit i enables writedata[8i+7:8i].
- waitrequest  out  1  request not accepted this cycle.
- readdata  out  32  read data, meaningful only when readdatavalid=1.
- readdatavalid  out  1  readdata valid.
- proto_err  out  1  sticky protocol-violation flag.

Function
REQ-007 A request SHALL be accepted in a cycle where (read or write)=1 and waitrequest=0.
REQ-008 State machine SHALL have states INIT, SERVE, REFRESH; reset SHALL enter INIT.
REQ-009 INIT: SHALL write 0 to addresses 0..2^ADDR_W-1, one word per cycle, ascending; waitrequest=1 throughout; then go to SERVE and clear refresh counter to 0.
REQ-010 SERVE: refresh counter SHALL increment every cycle; in the cycle it equals REF_PERIOD-1 the next state SHALL be REFRESH and the counter SHALL wrap to 0.
REQ-011 REFRESH: waitrequest=1 for exactly REF_CYCLES cycles, then return to SERVE; refresh counter SHALL keep counting during REFRESH.
REQ-012 waitrequest SHALL be combinational: 1 when state is INIT or REFRESH, or when pending reads = MAX_PEND; otherwise 0.
REQ-013 Accepted write SHALL update enabled bytes only at the clock edge ending the accept cycle; disabled bytes SHALL be unchanged; byteenable=0000 is a legal no-op.
REQ-014 Accepted read SHALL sample memory contents at acceptance (after all previously accepted writes) and present them on readdata with readdatavalid=1 exactly READ_LAT cycles later, for one cycle.
REQ-015 Reads SHALL complete in acceptance order; back-to-back reads SHALL be accepted every cycle while pending < MAX_PEND.
REQ-016 Pending count SHALL increment on read acceptance, decrement on readdatavalid, and be unchanged when both occur in the same cycle.
REQ-017 In-flight reads SHALL continue to complete during REFRESH.
REQ-018 read=1 and write=1 together while waitrequest=0 SHALL be treated as a write only and SHALL set proto_err; proto_err SHALL stay 1 until reset.
REQ-019 When readdatavalid=0, readdata SHALL be 0.

Reset
REQ-020 On reset=1 at a rising edge: state=INIT, init address=0, refresh counter=0, pending=0, read pipeline cleared, readdatavalid=0, readdata=0, proto_err=0, waitrequest=1.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight reads with no readdatavalid pulse; memory contents SHALL be re-zeroed by INIT.

Verification
REQ-022 Reset, ADDR_W=4 -> waitrequest=1 for 16 cycles, then 0; read of any address returns 0x00000000.
REQ-023 Write 0xDEADBEEF to addr 5 with byteenable=1111, then write 0x11223344 to addr 5 with byteenable=0101, then read addr 5 -> readdata=0xDE22BE44 exactly READ_LAT cycles after read acceptance.
REQ-024 Four consecutive reads with MAX_PEND=2, READ_LAT=3 -> only two accepted back-to-back, waitrequest=1 until the first readdatavalid, all four returned in issue order.
REQ-025 Continuous read traffic in SERVE -> waitrequest=1 for exactly REF_CYCLES cycles every REF_PERIOD cycles; in-flight reads still return during the stall.
REQ-026 read=1 and write=1 with writedata=0xA5A5A5A5 to addr 2 -> no readdatavalid for that request, addr 2 reads back 0xA5A5A5A5, proto_err=1 and stays 1 until reset.
REQ-027 Reset asserted one cycle after a read acceptance -> no readdatavalid follows; proto_err=0 and waitrequest=1 during INIT.

Source files
------------

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave memory model: zero-initialised word memory with fixed
// read latency, a bounded number of reads in flight, periodic refresh
// stalls and a sticky flag for simultaneous read/write requests.
//
// Parameter ranges: READ_LAT 1..8, MAX_PEND 1..READ_LAT, REF_PERIOD >= 8,
// REF_CYCLES 1..REF_PERIOD-1.
module avalon_mem_responder #(
   parameter int ADDR_W     = 10,
   parameter int READ_LAT   = 3,
   parameter int MAX_PEND   = 2,
   parameter int REF_PERIOD = 64,
   parameter int REF_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic [3:0]        byteenable,
   output logic              waitrequest,
   output logic [31:0]       readdata,
   output logic              readdatavalid,
   output logic              proto_err
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int RC_W  = $clog2(REF_PERIOD);
   localparam int PW    = $clog2(MAX_PEND + 1);

   typedef enum logic [1:0] {
      INIT    = 2'd0,
      SERVE   = 2'd1,
      REFRESH = 2'd2
   } state_t;

   // Control state
   state_t            state_q,     state_d;
   logic [ADDR_W-1:0] init_addr_q, init_addr_d;
   logic [RC_W-1:0]   ref_cnt_q,   ref_cnt_d;
   logic [PW-1:0]     pend_q,      pend_d;
   logic              proto_err_q, proto_err_d;

   // Read return pipeline: valid bits are control, data words are not reset
   logic [READ_LAT-1:0] rd_vld_q, rd_vld_d;
   logic [31:0]         rd_data_q [READ_LAT];
   logic [31:0]         rd_data_d [READ_LAT];

   // Storage and its single write port
   logic [31:0]       mem_q [DEPTH];
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [31:0]       mem_wdata;

   logic        wait_int;
   logic        acc_any;
   logic        acc_wr;
   logic        acc_rd;
   logic        acc_both;
   logic        rdv_int;
   logic [31:0] rd_sample;

   // Stall decision and request classification; write wins over read
   always_comb begin
      wait_int = 1'b0;
      if (state_q != SERVE) begin
         wait_int = 1'b1;
      end else if (pend_q == PW'(MAX_PEND)) begin
         wait_int = 1'b1;
      end
      acc_any  = (read | write) & ~wait_int;
      acc_wr   = write & acc_any;
      acc_rd   = read & ~write & acc_any;
      acc_both = read & write & acc_any;
      rdv_int  = rd_vld_q[READ_LAT-1];
   end

   // Next-state logic for INIT sweep, serving and refresh stalls
   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      ref_cnt_d   = ref_cnt_q;
      unique case (state_q)
         INIT: begin
            if (init_addr_q == {ADDR_W{1'b1}}) begin
               state_d     = SERVE;
               init_addr_d = '0;
               ref_cnt_d   = '0;
            end else begin
               init_addr_d = init_addr_q + ADDR_W'(1);
            end
         end
         SERVE: begin
            if (ref_cnt_q == RC_W'(REF_PERIOD - 1)) begin
               state_d   = REFRESH;
               ref_cnt_d = '0;
            end else begin
               ref_cnt_d = ref_cnt_q + RC_W'(1);
            end
         end
         REFRESH: begin
            // The counter wrapped to 0 on entry, so it also times the stall
            ref_cnt_d = ref_cnt_q + RC_W'(1);
            if (ref_cnt_q == RC_W'(REF_CYCLES - 1)) begin
               state_d = SERVE;
            end
         end
         default: begin
            state_d     = INIT;
            init_addr_d = '0;
            ref_cnt_d   = '0;
         end
      endcase
   end

   // Memory write port: INIT sweep zeroes words, otherwise accepted writes
   always_comb begin
      mem_we    = 4'b0000;
      mem_waddr = address;
      mem_wdata = writedata;
      if (state_q == INIT) begin
         mem_we    = 4'b1111;
         mem_waddr = init_addr_q;
         mem_wdata = 32'h0000_0000;
      end else if (acc_wr) begin
         mem_we = byteenable;
      end
   end

   // Read sampling, return pipeline advance, in-flight count and error flag
   always_comb begin
      rd_sample = mem_q[address];
      rd_vld_d  = '0;
      rd_vld_d[0]  = acc_rd;
      rd_data_d[0] = rd_sample;
      for (int i = 1; i < READ_LAT; i++) begin
         rd_vld_d[i]  = rd_vld_q[i-1];
         rd_data_d[i] = rd_data_q[i-1];
      end
      pend_d      = pend_q + PW'(acc_rd) - PW'(rdv_int);
      proto_err_d = proto_err_q | acc_both;
   end

   // Control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= INIT;
         init_addr_q <= '0;
         ref_cnt_q   <= '0;
         pend_q      <= '0;
         rd_vld_q    <= '0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         ref_cnt_q   <= ref_cnt_d;
         pend_q      <= pend_d;
         rd_vld_q    <= rd_vld_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Read data words follow their valid bits; output gating hides stale data
   always_ff @(posedge clk) begin
      for (int i = 0; i < READ_LAT; i++) begin
         rd_data_q[i] <= rd_data_d[i];
      end
   end

   // Byte-lane memory writes
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (mem_we[b]) begin
            mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   assign waitrequest   = wait_int;
   assign readdatavalid = rdv_int;
   assign readdata      = rdv_int ? rd_data_q[READ_LAT-1] : 32'h0000_0000;
   assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed bench for avalon_mem_responder: stimulus pushes expected read
// responses into a queue, an independent monitor pops and checks them.
module tb_avalon_mem_responder;

   localparam int ADDR_W     = 4;
   localparam int READ_LAT   = 3;
   localparam int MAX_PEND   = 2;
   localparam int REF_PERIOD = 32;
   localparam int REF_CYCLES = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic [3:0]        byteenable;
   logic              waitrequest;
   logic [31:0]       readdata;
   logic              readdatavalid;
   logic              proto_err;

   avalon_mem_responder #(
      .ADDR_W    (ADDR_W),
      .READ_LAT  (READ_LAT),
      .MAX_PEND  (MAX_PEND),
      .REF_PERIOD(REF_PERIOD),
      .REF_CYCLES(REF_CYCLES)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .address      (address),
      .read         (read),
      .write        (write),
      .writedata    (writedata),
      .byteenable   (byteenable),
      .waitrequest  (waitrequest),
      .readdata     (readdata),
      .readdatavalid(readdatavalid),
      .proto_err    (proto_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   logic [31:0] vals [4];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Monitor: every returned word must match the oldest expectation, on time
   always @(negedge clk) begin
      if (mon_en) begin
         if (readdatavalid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rdv: got readdata 0x%08h, expected no response", readdata);
            end else begin
               mon_e = exp_q.pop_front();
               check("rd_data", readdata, mon_e.data);
               check("rd_latency", 32'(cyc), 32'(mon_e.due));
            end
         end else begin
            check("rd_zero_when_idle", readdata, 32'h0);
         end
      end
   end

   task automatic wait_accept(input string name, output bit ok);
      int n = 0;
      ok = 1'b1;
      @(negedge clk);
      while (waitrequest) begin
         n++;
         if (n > 200) begin
            fail_timeout(name);
            ok = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic both);
      bit ok;
      @(posedge clk); #1;
      address = a; writedata = d; byteenable = be; write = 1'b1; read = both;
      wait_accept("write_accept", ok);
      @(posedge clk); #1;
      write = 1'b0; read = 1'b0;
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp);
      bit ok;
      @(posedge clk); #1;
      address = a; read = 1'b1;
      wait_accept("read_accept", ok);
      if (ok) exp_q.push_back('{data: exp, due: cyc + READ_LAT});
      @(posedge clk); #1;
      read = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0) begin
         @(negedge clk);
         n++;
         if (n > 100) begin
            fail_timeout("drain");
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   // Returns at the negedge of the first serving cycle after a refresh stall
   task automatic sync_refresh(output int t);
      int n = 0;
      wait_idle();
      while (!waitrequest) begin
         @(negedge clk);
         n++;
         if (n > 200) begin fail_timeout("sync_refresh_start"); break; end
      end
      while (waitrequest) begin
         @(negedge clk);
         n++;
         if (n > 400) begin fail_timeout("sync_refresh_end"); break; end
      end
      t = cyc;
   endtask

   task automatic count_init(output int nw, output int nr);
      nw = 0;
      nr = 0;
      forever begin
         @(negedge clk);
         if (readdatavalid) nr++;
         if (!waitrequest) break;
         nw++;
         if (nw > 100) begin fail_timeout("init_sweep"); break; end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  nw, nr, t0, n, nv;
      int  acc_cyc [4];
      bit  ok;

      vals = '{32'h1357_9BDF, 32'h2468_ACE0, 32'h0F0F_F0F0, 32'h8000_0001};
      reset = 1'b1; address = '0; read = 1'b0; write = 1'b0;
      writedata = '0; byteenable = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_waitrequest", 32'(waitrequest), 32'd1);
      check("rst_readdatavalid", 32'(readdatavalid), 32'd0);
      check("rst_readdata", readdata, 32'h0);
      check("rst_proto_err", 32'(proto_err), 32'd0);
      mon_en = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;

      // INIT sweep length and zeroed contents
      count_init(nw, nr);
      check("init_wait_cycles", 32'(nw), 32'd16);
      check("init_no_rdv", 32'(nr), 32'd0);
      do_read(4'd3, 32'h0000_0000);
      do_read(4'd15, 32'h0000_0000);

      // Byte-enable merging, and an all-disabled write as a no-op
      do_write(4'd5, 32'hDEAD_BEEF, 4'b1111, 1'b0);
      do_write(4'd5, 32'h1122_3344, 4'b0101, 1'b0);
      do_read(4'd5, 32'hDE22_BE44);
      do_write(4'd5, 32'hFFFF_FFFF, 4'b0000, 1'b0);
      do_read(4'd5, 32'hDE22_BE44);

      // Back-to-back reads limited by the in-flight bound
      for (int i = 0; i < 4; i++) do_write(ADDR_W'(6 + i), vals[i], 4'b1111, 1'b0);
      sync_refresh(t0);
      @(posedge clk); #1;
      read = 1'b1; address = 4'd6;
      n = 0;
      for (int i = 0; i < 4; ) begin
         @(negedge clk);
         if (!waitrequest) begin
            acc_cyc[i] = cyc;
            exp_q.push_back('{data: vals[i], due: cyc + READ_LAT});
            i++;
         end
         n++;
         if (n > 60) begin fail_timeout("burst_accept"); break; end
         @(posedge clk); #1;
         address = ADDR_W'(6 + i);
      end
      read = 1'b0;
      check("burst_acc1_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
      check("burst_acc2_gap", 32'(acc_cyc[2] - acc_cyc[0]), 32'd4);
      check("burst_acc3_gap", 32'(acc_cyc[3] - acc_cyc[0]), 32'd5);
      wait_idle();

      // Refresh cadence, with reads in flight across a stall
      sync_refresh(t0);
      repeat (26) @(posedge clk);
      #1;
      read = 1'b1; address = 4'd5;
      @(negedge clk);
      check("pre_refresh_accept0", 32'(waitrequest), 32'd0);
      if (!waitrequest) exp_q.push_back('{data: 32'hDE22_BE44, due: cyc + READ_LAT});
      @(posedge clk); #1;
      address = 4'd9;
      @(negedge clk);
      check("pre_refresh_accept1", 32'(waitrequest), 32'd0);
      if (!waitrequest) exp_q.push_back('{data: vals[3], due: cyc + READ_LAT});
      @(posedge clk); #1;
      read = 1'b0;
      @(negedge clk);
      check("refresh1_offset", 32'(cyc - t0), 32'd28);
      check("refresh1_wait", 32'(waitrequest), 32'd1);
      n = 1; nv = 0;
      forever begin
         @(negedge clk);
         if (!waitrequest) break;
         n++;
         if (readdatavalid) nv++;
         if (n > 50) begin fail_timeout("refresh1_len"); break; end
      end
      check("refresh1_len", 32'(n), 32'd4);
      check("refresh1_rdv_in_stall", 32'(nv), 32'd2);
      n = 0;
      while (!waitrequest) begin
         @(negedge clk);
         n++;
         if (n > 100) begin fail_timeout("refresh2_start"); break; end
      end
      check("refresh2_offset", 32'(cyc - t0), 32'd60);
      n = 0;
      while (waitrequest) begin
         @(negedge clk);
         n++;
         if (n > 50) begin fail_timeout("refresh2_len"); break; end
      end
      check("refresh2_len", 32'(n), 32'd4);

      // Simultaneous read and write: write only, sticky error flag
      wait_idle();
      do_write(4'd2, 32'hA5A5_A5A5, 4'b1111, 1'b1);
      repeat (6) @(negedge clk);
      check("proto_err_set", 32'(proto_err), 32'd1);
      do_read(4'd2, 32'hA5A5_A5A5);
      do_write(4'd3, 32'h0000_1234, 4'b1111, 1'b0);
      do_read(4'd3, 32'h0000_1234);
      wait_idle();
      check("proto_err_sticky", 32'(proto_err), 32'd1);

      // Reset one cycle after a read acceptance drops it and re-zeroes memory
      @(posedge clk); #1;
      read = 1'b1; address = 4'd5;
      wait_accept("reset_read_accept", ok);
      @(posedge clk); #1;
      read = 1'b0; reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst2_proto_err", 32'(proto_err), 32'd0);
      check("rst2_waitrequest", 32'(waitrequest), 32'd1);
      check("rst2_readdatavalid", 32'(readdatavalid), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      count_init(nw, nr);
      check("rst2_init_wait_cycles", 32'(nw), 32'd16);
      check("rst2_no_rdv", 32'(nr), 32'd0);
      do_read(4'd5, 32'h0000_0000);
      do_read(4'd2, 32'h0000_0000);
      wait_idle();
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
